// File: rtl/tdc_pkg.sv
// Constants and state encoding shared by the TDC link transmitter and receiver.
package tdc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int TDC_CLKS_PER_BIT_DEF = 434;
    localparam int TDC_WORD_BYTES_DEF   = 2;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-cell sampling FSM and bit-cell counter.
module uart_rx_byte
    import tdc_pkg::*;
#(
    parameter int CLKS_PER_BIT = TDC_CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_ok,
    output logic       byte_err,
    output logic       in_idle
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CELL_LAST = CW'(CLKS_PER_BIT - 1);

    rx_state_t     state;
    rx_state_t     state_nxt;
    logic          rx_s1;
    logic          rx_s2;
    logic [CW-1:0] cell_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          cell_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    // START waits half a cell so every later sample lands mid-cell.
    always_comb begin
        cell_done = 1'b0;
        if (state == START)
            cell_done = (cell_cnt == HALF_LAST);
        else if (state == DATA || state == STOP)
            cell_done = (cell_cnt == CELL_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_s2) state_nxt = START;
            START:   if (cell_done) state_nxt = rx_s2 ? IDLE : DATA;
            DATA:    if (cell_done && bit_idx == 3'd7) state_nxt = STOP;
            STOP:    if (cell_done) state_nxt = rx_s2 ? IDLE : BREAK;
            BREAK:   if (rx_s2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_ok  = (state == STOP) && cell_done && rx_s2;
        byte_err = (state == STOP) && cell_done && !rx_s2;
        in_idle  = (state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cell_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            if (state == IDLE || state == BREAK || cell_done)
                cell_cnt <= '0;
            else
                cell_cnt <= cell_cnt + CW'(1);
            if (state != DATA)
                bit_idx <= '0;
            else if (cell_done && bit_idx != 3'd7)
                bit_idx <= bit_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && cell_done)
            shreg <= {rx_s2, shreg[7:1]};
    end

    assign byte_data = shreg;

endmodule

// File: rtl/tdc_frame_rx.sv
// TDC link receiver: assembles BYTES serial bytes (LSB byte first) into one measurement word.
module tdc_frame_rx
    import tdc_pkg::*;
#(
    parameter int CLKS_PER_BIT = TDC_CLKS_PER_BIT_DEF,
    parameter int BYTES        = TDC_WORD_BYTES_DEF,
    parameter int IDLE_BITS    = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    output logic [8*BYTES-1:0] data,
    output logic               valid,
    output logic               frame_err,
    output logic               timeout,
    output logic               busy
);

    localparam int IW        = $clog2(BYTES) + 1;
    localparam int GAP_LIMIT = IDLE_BITS * CLKS_PER_BIT;
    localparam int GW        = $clog2(GAP_LIMIT + 1);

    logic [7:0]         byte_data;
    logic               byte_ok;
    logic               byte_err;
    logic               in_idle;
    logic [IW-1:0]      byte_idx;
    logic [8*BYTES-1:0] asm_word;
    logic [8*BYTES-1:0] asm_next;
    logic [GW-1:0]      gap_cnt;
    logic [GW-1:0]      gap_nxt;
    logic               gap_run;
    logic               gap_hit;
    logic               last_byte;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .byte_data(byte_data),
        .byte_ok  (byte_ok),
        .byte_err (byte_err),
        .in_idle  (in_idle)
    );

    always_comb begin
        asm_next = asm_word;
        asm_next[8*int'(byte_idx) +: 8] = byte_data;
    end

    assign last_byte = (byte_idx == IW'(BYTES - 1));
    // The gap timer only matters once part of a word has arrived.
    assign gap_run   = in_idle && (byte_idx != '0);
    assign gap_nxt   = gap_cnt + GW'(1);
    assign gap_hit   = gap_run && (gap_nxt == GW'(GAP_LIMIT));
    assign busy      = !in_idle;

    always_ff @(posedge clk) begin
        if (byte_ok)
            asm_word <= asm_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
            byte_idx  <= '0;
            gap_cnt   <= '0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
            if (byte_ok) begin
                if (last_byte) begin
                    data     <= asm_next;
                    valid    <= 1'b1;
                    byte_idx <= '0;
                end else begin
                    byte_idx <= byte_idx + IW'(1);
                end
            end else if (byte_err) begin
                frame_err <= 1'b1;
                byte_idx  <= '0;
            end else if (gap_hit) begin
                timeout  <= 1'b1;
                byte_idx <= '0;
            end
            if (!gap_run || gap_hit)
                gap_cnt <= '0;
            else
                gap_cnt <= gap_nxt;
        end
    end

endmodule
